uart_transmitter: RTL and testbench

- 8N1 UART serializer that drives the CPU's FPGA_SERIAL_TX pin.
- It is the transmit-side counterpart of the CPU's serial receive path (FPGA_SERIAL_RX).
- It accepts bytes from the memory-mapped UART TX register through a ready/valid handshake and shifts them out LSB first at a fixed baud rate.
- It sits inside Riscv151 next to the receiver and shares the receiver's CLOCK_FREQ/BAUD_RATE parameters.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_baud_counter.sv | 35 +++
 rtl/uart_transmitter.sv | 118 +++++++++++
 tb/tb_uart_transmitter.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame geometry and baud-timing helpers.
// The transmitter and the receiver both import this package.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;

  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // A width of at least one bit keeps degenerate parameter sets elaborating up to the range check.
  function automatic int clock_counter_width(input int edge_time);
    return (edge_time < 2) ? 1 : $clog2(edge_time);
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Bit-period timer: counts 0..SYMBOL_EDGE_TIME-1 while enabled and pulses bit_done on the last count.
// The receiver instantiates this same block.
module uart_baud_counter
  import uart_pkg::*;
#(
  parameter int SYMBOL_EDGE_TIME = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic bit_done
);

  localparam int CW = clock_counter_width(SYMBOL_EDGE_TIME);
  localparam logic [CW-1:0] LAST_COUNT = CW'(SYMBOL_EDGE_TIME - 1);

  logic [CW-1:0] count_r;

  assign bit_done = enable && (count_r == LAST_COUNT);

  // Count register; it holds at zero outside a frame, so each frame starts with a fresh phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear || bit_done) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter: accepts a byte over ready/valid and shifts it out LSB first
// on serial_out, framed by a low start bit and a high stop bit.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  if (SYMBOL_EDGE_TIME < 2) begin : g_bad_baud
    $error("uart_transmitter: CLOCK_FREQ/BAUD_RATE must be at least 2");
  end

  uart_state_t                 state_r,   state_s;
  logic [FRAME_BITS-2:0]       shift_r,   shift_s;
  logic [2:0]                  bit_cnt_r, bit_cnt_s;
  logic                        serial_r,  serial_s;
  logic                        handshake_s;
  logic                        bit_done_s;

  assign data_in_ready = (state_r == IDLE);
  assign handshake_s   = data_in_valid && data_in_ready;
  assign serial_out    = serial_r;

  uart_baud_counter #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME)
  ) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clear   (handshake_s),
    .enable  (state_r != IDLE),
    .bit_done(bit_done_s)
  );

  // FSM, frame shifter and line register; the start bit goes on the line at the accepting edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      shift_r   <= '0;
      bit_cnt_r <= 3'd0;
      serial_r  <= 1'b1;
    end else begin
      state_r   <= state_s;
      shift_r   <= shift_s;
      bit_cnt_r <= bit_cnt_s;
      serial_r  <= serial_s;
    end
  end

  // Next-state logic; shift_r holds the not-yet-sent frame bits {stop, data[7:0]}.
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    bit_cnt_s = bit_cnt_r;
    serial_s  = serial_r;
    case (state_r)
      IDLE: begin
        if (handshake_s) begin
          state_s   = START;
          shift_s   = {1'b1, data_in};
          bit_cnt_s = 3'd0;
          serial_s  = 1'b0;
        end else begin
          serial_s  = 1'b1;
        end
      end
      START: begin
        if (bit_done_s) begin
          state_s   = DATA;
          serial_s  = shift_r[0];
          shift_s   = {1'b1, shift_r[FRAME_BITS-2:1]};
          bit_cnt_s = 3'd0;
        end else begin
          state_s   = START;
        end
      end
      DATA: begin
        if (bit_done_s) begin
          serial_s = shift_r[0];
          shift_s  = {1'b1, shift_r[FRAME_BITS-2:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_s   = STOP;
            bit_cnt_s = 3'd0;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (bit_done_s) begin
          state_s  = IDLE;
          serial_s = 1'b1;
        end else begin
          state_s  = STOP;
        end
      end
      default: begin
        state_s   = IDLE;
        shift_s   = '0;
        bit_cnt_s = 3'd0;
        serial_s  = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Self-checking bench for uart_transmitter: a fast instance (4 cycles/bit) runs the vector table,
// a default-rate instance (434 cycles/bit) runs the multi-cycle corner sequences.
module tb_uart_transmitter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       f_valid = 1'b0;
  logic       s_valid = 1'b0;
  logic       f_ready, f_ser, s_ready, s_ser;
  logic       sel = 1'b1;
  logic       mon_ser, mon_ready;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ready_fall[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit i = line level of symbol i (start first)
    string      name;
  } vec_t;

  vec_t vecs[7];

  uart_transmitter #(.CLOCK_FREQ(1_000_000), .BAUD_RATE(250_000)) dut_f (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(f_valid),
    .data_in_ready(f_ready), .serial_out(f_ser)
  );

  uart_transmitter dut_s (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(s_valid),
    .data_in_ready(s_ready), .serial_out(s_ser)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge s_ready) if (!rst) ready_fall.push_back(cyc);

  assign mon_ser   = sel ? s_ser : f_ser;
  assign mon_ready = sel ? s_ready : f_ready;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Called at the falling edge just after a handshake edge.
  task automatic check_frame(input logic [9:0] exp, input string name);
    int set;
    int bad_lvl;
    int bad_rdy;
    set = sel ? 434 : 4;
    bad_lvl = 0;
    bad_rdy = 0;
    for (int k = 0; k < 10 * set; k++) begin
      if (mon_ser !== exp[k / set]) bad_lvl++;
      if (mon_ready !== 1'b0) bad_rdy++;
      @(negedge clk);
    end
    check({name, "_levels"}, bad_lvl, 0);
    check({name, "_ready_low"}, bad_rdy, 0);
    check({name, "_ready_after"}, int'(mon_ready), 1);
    check({name, "_line_after"}, int'(mon_ser), 1);
  endtask

  task automatic check_idle(input int n, input string name);
    int bad;
    bad = 0;
    for (int k = 0; k < n; k++) begin
      if (mon_ser !== 1'b1 || mon_ready !== 1'b1) bad++;
      @(negedge clk);
    end
    check({name, "_idle"}, bad, 0);
  endtask

  task automatic send(input logic [7:0] b);
    data_in = b;
    if (sel) s_valid = 1'b1; else f_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    f_valid = 1'b0;
    data_in = ~b;
  endtask

  logic [7:0] bb_data[4]  = '{8'h00, 8'hFF, 8'hA5, 8'h5A};
  logic [9:0] bb_frame[4] = '{10'h200, 10'h3FE, 10'h34A, 10'h2B4};

  initial begin
    vecs[0] = '{8'hC3, 10'h386, "v_c3"};
    vecs[1] = '{8'h41, 10'h282, "v_41"};
    vecs[2] = '{8'h00, 10'h200, "v_00"};
    vecs[3] = '{8'hFF, 10'h3FE, "v_ff"};
    vecs[4] = '{8'hA5, 10'h34A, "v_a5"};
    vecs[5] = '{8'h5A, 10'h2B4, "v_5a"};
    vecs[6] = '{8'h7E, 10'h2FC, "v_7e"};

    // Reset state, sampled while rst is still held.
    repeat (2) @(negedge clk);
    check("rst_f_ready", int'(f_ready), 1);
    check("rst_f_line", int'(f_ser), 1);
    check("rst_s_ready", int'(s_ready), 1);
    check("rst_s_line", int'(s_ser), 1);
    rst = 1'b0;
    @(negedge clk);

    // Vector table on the 4-cycles-per-bit instance.
    sel = 1'b0;
    for (int i = 0; i < 7; i++) begin
      send(vecs[i].data);
      check_frame(vecs[i].frame, vecs[i].name);
      check_idle(12, vecs[i].name);
    end

    // Default rate: single 0x41 frame.
    sel = 1'b1;
    check_idle(5, "s_pre");
    send(8'h41);
    check_frame(10'h282, "s_41");

    // Back-to-back bytes with valid held high.
    ready_fall.delete();
    data_in = bb_data[0];
    s_valid = 1'b1;
    for (int j = 0; j < 4; j++) begin
      @(posedge clk);
      @(negedge clk);
      if (j < 3) data_in = bb_data[j + 1];
      else begin
        s_valid = 1'b0;
        data_in = 8'h3C;
      end
      check_frame(bb_frame[j], "b2b");
    end
    check_idle(500, "b2b_tail");
    check("b2b_frames", ready_fall.size(), 4);
    if (ready_fall.size() == 4) begin
      for (int j = 1; j < 4; j++) check("b2b_spacing", ready_fall[j] - ready_fall[j - 1], 4341);
    end

    // Valid pulsed mid-frame must be ignored.
    send(8'h33);
    fork
      check_frame(10'h266, "busy_33");
      begin
        repeat (1000) @(negedge clk);
        data_in = 8'h12;
        s_valid = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
      end
    join
    check_idle(500, "busy_no_12");

    // Reset mid-frame: line high at once, frame abandoned, next byte clean.
    send(8'h96);
    repeat (1999) @(negedge clk);
    check("rst_pre_line", int'(s_ser), 0);
    rst = 1'b1;
    #1;
    check("rst_mid_line", int'(s_ser), 1);
    check("rst_mid_ready", int'(s_ready), 1);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_rel_ready", int'(s_ready), 1);
    check_idle(500, "rst_no_resend");
    send(8'h7E);
    check_frame(10'h2FC, "post_rst_7e");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
